// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - HI/LO multiply/divide unit with EX-stage stall control
module muldiv_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid,
    input  logic        flush,
    input  logic        is_mult,
    input  logic        is_multu,
    input  logic        is_div,
    input  logic        is_divu,
    input  logic        hi_wen,
    input  logic        lo_wen,
    input  logic        rd_hi,
    input  logic        rd_lo,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        stall,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] result
);
    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t      state, state_next;
    logic [4:0]  cnt;
    logic        req, accept;
    logic [31:0] op_a, op_b, rem;
    logic        mul_sgn, neg_q, neg_r, div_last;
    logic [63:0] prod, prod_next;
    logic [32:0] trial;
    logic [31:0] mag_a, mag_b, q_fix, r_fix;

    assign req    = valid & ~flush &
                    (is_mult | is_multu | is_div | is_divu | hi_wen | lo_wen | rd_hi | rd_lo);
    assign busy   = (state != IDLE);
    assign stall  = req & busy;
    assign accept = req & ~busy;
    assign result = rd_hi ? hi : (rd_lo ? lo : 32'd0);

    // Sign-extending both operands to 64 bits lets one unsigned multiplier serve mult and multu.
    assign prod_next = {{32{mul_sgn & op_a[31]}}, op_a} * {{32{mul_sgn & op_b[31]}}, op_b};

    assign mag_a = (is_div & src_a[31]) ? (32'd0 - src_a) : src_a;
    assign mag_b = (is_div & src_b[31]) ? (32'd0 - src_b) : src_b;
    assign trial = {rem, op_a[31]} - {1'b0, op_b};
    assign q_fix = neg_q ? (32'd0 - op_a) : op_a;
    assign r_fix = neg_r ? (32'd0 - rem) : rem;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept && (is_mult || is_multu)) begin
                    state_next = MUL;
                end else if (accept && (is_div || is_divu)) begin
                    state_next = DIV;
                end
            end
            MUL:     if (cnt == 5'd1) state_next = IDLE;
            DIV:     if (div_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= 5'd0;
            hi       <= 32'd0;
            lo       <= 32'd0;
            op_a     <= 32'd0;
            op_b     <= 32'd0;
            rem      <= 32'd0;
            prod     <= 64'd0;
            mul_sgn  <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_last <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt      <= 5'd0;
                        div_last <= 1'b0;
                        rem      <= 32'd0;
                        mul_sgn  <= is_mult;
                        neg_q    <= is_div & (src_a[31] ^ src_b[31]);
                        neg_r    <= is_div & src_a[31];
                        op_a     <= mag_a;
                        op_b     <= mag_b;
                        if (hi_wen) hi <= src_a;
                        if (lo_wen) lo <= src_a;
                    end
                end
                MUL: begin
                    if (cnt == 5'd0) begin
                        prod <= prod_next;
                        cnt  <= 5'd1;
                    end else begin
                        hi  <= prod[63:32];
                        lo  <= prod[31:0];
                        cnt <= 5'd0;
                    end
                end
                DIV: begin
                    if (div_last) begin
                        hi       <= r_fix;
                        lo       <= q_fix;
                        div_last <= 1'b0;
                    end else begin
                        // Restoring step: keep the subtraction only when it does not go negative.
                        if (!trial[32]) begin
                            rem  <= trial[31:0];
                            op_a <= {op_a[30:0], 1'b1};
                        end else begin
                            rem  <= {rem[30:0], op_a[31]};
                            op_a <= {op_a[30:0], 1'b0};
                        end
                        cnt <= cnt + 5'd1;
                        if (cnt == 5'd31) div_last <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - table, directed and randomized checks for muldiv_ctrl
module tb_muldiv_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        valid, flush;
    logic        is_mult, is_multu, is_div, is_divu;
    logic        hi_wen, lo_wen, rd_hi, rd_lo;
    logic [31:0] src_a, src_b;
    logic        stall, busy;
    logic [31:0] hi, lo, result;

    int errors = 0;
    int checks = 0;

    muldiv_ctrl dut (
        .clk(clk), .reset(reset), .valid(valid), .flush(flush),
        .is_mult(is_mult), .is_multu(is_multu), .is_div(is_div), .is_divu(is_divu),
        .hi_wen(hi_wen), .lo_wen(lo_wen), .rd_hi(rd_hi), .rd_lo(rd_lo),
        .src_a(src_a), .src_b(src_b),
        .stall(stall), .busy(busy), .hi(hi), .lo(lo), .result(result)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        valid = 0; flush = 0;
        is_mult = 0; is_multu = 0; is_div = 0; is_divu = 0;
        hi_wen = 0; lo_wen = 0; rd_hi = 0; rd_lo = 0;
        src_a = 0; src_b = 0;
    endtask

    // op: 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6 mfhi, 7 mflo
    task automatic set_op(input int op, input logic [31:0] a, input logic [31:0] b);
        idle_in();
        valid = 1;
        case (op)
            0: is_mult = 1;
            1: is_multu = 1;
            2: is_div = 1;
            3: is_divu = 1;
            4: hi_wen = 1;
            5: lo_wen = 1;
            6: rd_hi = 1;
            7: rd_lo = 1;
            default: valid = 0;
        endcase
        src_a = a;
        src_b = b;
    endtask

    function automatic logic [63:0] model(input int op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p = 64'd0;
        case (op)
            0: p = sa * sb;
            1: p = {32'd0, a} * {32'd0, b};
            2: begin
                if (b == 32'd0) begin
                    p = {a, (sa < 0) ? 32'd1 : 32'hFFFFFFFF};
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end
            end
            3: p = (b == 32'd0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
            default: p = 64'd0;
        endcase
        return p;
    endfunction

    task automatic run_op(input string tag, input int op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo);
        int n;
        set_op(op, a, b);
        #1;
        chk($sformatf("%s issue_stall", tag), 32'(stall), 32'd0);
        tick();
        idle_in();
        n = 0;
        while (busy && n < 64) begin
            n++;
            tick();
        end
        chk($sformatf("%s busy_cycles", tag), 32'(n), (op < 2) ? 32'd2 : 32'd33);
        chk($sformatf("%s hi", tag), hi, ehi);
        chk($sformatf("%s lo", tag), lo, elo);
        set_op(6, 32'd0, 32'd0);
        #1;
        chk($sformatf("%s mfhi", tag), result, ehi);
        tick();
        set_op(7, 32'd0, 32'd0);
        #1;
        chk($sformatf("%s mflo", tag), result, elo);
        tick();
        idle_in();
    endtask

    initial begin
        int n;
        logic [63:0] e;
        int op;
        logic [31:0] a, b;

        tbl[0] = '{1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        tbl[1] = '{2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        tbl[2] = '{3, 32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF};
        tbl[3] = '{2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        tbl[4] = '{0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        tbl[5] = '{0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
        tbl[6] = '{3, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};
        tbl[7] = '{2, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'h00000001};
        tbl[8] = '{2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};

        idle_in();
        reset = 1;
        repeat (2) tick();
        reset = 0;
        set_op(6, 32'd0, 32'd0);
        #1;
        chk("reset hi", hi, 32'd0);
        chk("reset lo", lo, 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset stall", 32'(stall), 32'd0);
        chk("reset mfhi", result, 32'd0);
        tick();
        idle_in();

        // mult -1 x 2 with MFLO queued right behind it
        set_op(0, 32'hFFFFFFFF, 32'h00000002);
        #1;
        chk("mflo_after_mult issue_stall", 32'(stall), 32'd0);
        tick();
        set_op(7, 32'd0, 32'd0);
        #1;
        chk("mflo_after_mult stall_t1", 32'(stall), 32'd1);
        tick();
        chk("mflo_after_mult stall_t2", 32'(stall), 32'd1);
        tick();
        chk("mflo_after_mult stall_t3", 32'(stall), 32'd0);
        chk("mflo_after_mult result", result, 32'hFFFFFFFE);
        chk("mflo_after_mult hi", hi, 32'hFFFFFFFF);
        tick();
        idle_in();

        for (int i = 0; i < 9; i++) begin
            run_op($sformatf("tbl%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp_hi, tbl[i].exp_lo);
        end

        for (int i = 0; i < 40; i++) begin
            op = int'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 5) == 0) b = 32'd0;
            else if ($urandom_range(0, 3) == 0) b = $urandom_range(1, 15);
            else if ($urandom_range(0, 5) == 0) b = 32'hFFFFFFFF;
            e = model(op, a, b);
            run_op($sformatf("rnd%0d", i), op, a, b, e[63:32], e[31:0]);
        end

        // flush cancels a same-cycle divide
        set_op(4, 32'hAAAA5555, 32'd0);
        tick();
        set_op(5, 32'h13579BDF, 32'd0);
        tick();
        idle_in();
        chk("mthi_idle hi", hi, 32'hAAAA5555);
        chk("mtlo_idle lo", lo, 32'h13579BDF);
        set_op(2, 32'd100, 32'd7);
        flush = 1;
        #1;
        chk("flush_div stall", 32'(stall), 32'd0);
        tick();
        idle_in();
        chk("flush_div busy", 32'(busy), 32'd0);
        repeat (3) tick();
        chk("flush_div busy_later", 32'(busy), 32'd0);
        chk("flush_div hi", hi, 32'hAAAA5555);
        chk("flush_div lo", lo, 32'h13579BDF);

        // MTHI arriving while a divide is in flight
        set_op(3, 32'd100, 32'd7);
        tick();
        set_op(4, 32'h12345678, 32'd0);
        n = 0;
        while (stall && n < 64) begin
            n++;
            tick();
        end
        chk("mthi_busy stall_cycles", 32'(n), 32'd33);
        tick();
        idle_in();
        chk("mthi_busy hi", hi, 32'h12345678);
        chk("mthi_busy lo", lo, 32'd14);

        // flushed read during a divide must neither stall nor stop the divide
        set_op(3, 32'd1000, 32'd10);
        tick();
        set_op(6, 32'd0, 32'd0);
        flush = 1;
        #1;
        chk("flush_inflight stall", 32'(stall), 32'd0);
        tick();
        idle_in();
        n = 0;
        while (busy && n < 64) begin
            n++;
            tick();
        end
        chk("flush_inflight busy_cycles", 32'(n), 32'd32);
        chk("flush_inflight hi", hi, 32'd0);
        chk("flush_inflight lo", lo, 32'd100);

        // reset at cnt = 10 of a divide, with a competing MTHI in the same cycle
        set_op(4, 32'h0BADF00D, 32'd0);
        tick();
        set_op(2, 32'd100, 32'd3);
        tick();
        idle_in();
        repeat (10) tick();
        chk("reset_mid_div busy_before", 32'(busy), 32'd1);
        set_op(4, 32'hDEADBEEF, 32'd0);
        reset = 1;
        tick();
        reset = 0;
        idle_in();
        chk("reset_mid_div busy", 32'(busy), 32'd0);
        chk("reset_mid_div hi", hi, 32'd0);
        chk("reset_mid_div lo", lo, 32'd0);
        set_op(7, 32'd0, 32'd0);
        #1;
        chk("reset_mid_div mflo_stall", 32'(stall), 32'd0);
        chk("reset_mid_div mflo", result, 32'd0);
        tick();
        idle_in();
        repeat (40) tick();
        chk("reset_mid_div hi_later", hi, 32'd0);
        chk("reset_mid_div lo_later", lo, 32'd0);
        chk("reset_mid_div busy_later", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
